// File: rtl/uart_piso_tx_ctrl_if.sv
// Byte handshake between the producing logic and the UART PISO transmit controller.
interface uart_piso_tx_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_piso_tx_ctrl.sv
// Sequences an sn74ls166-style PISO register as a UART transmitter (start, 8 data LSB first, stop).
// Define UART_PARITY_EN to insert a parity bit before the stop bit; PARITY_ODD selects its sense.
module uart_piso_tx_ctrl #(
  parameter int CLK_DIV = 16
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic               clk,
  input  logic               clr_n,
  uart_piso_tx_ctrl_if.slave host,
  output logic               sr_clr_n,
  output logic               sr_sh_ld_n,
  output logic               sr_clk_inh,
  output logic               sr_ser,
  output logic [7:0]         sr_p,
  input  logic               sr_q,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_cnt, bit_next;
  logic             done_next;
  logic             accept;
  logic             baud_last;
`ifdef UART_PARITY_EN
  logic             parity_bit, parity_next;
`endif

  assign sr_clr_n      = clr_n;
  assign sr_ser        = 1'b1;
  assign host.tx_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = host.tx_valid && (state == IDLE);
  assign baud_last     = (baud_cnt == BAUD_LAST);

  // The register shifts out bit 7 first, so reverse the byte to put tx_data[0] on the line first.
  always_comb begin
    for (int i = 0; i < 8; i++) sr_p[i] = host.tx_data[7-i];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_done    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      tx_done    <= done_next;
`ifdef UART_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state;
    baud_next   = baud_last ? '0 : baud_cnt + CNT_W'(1);
    bit_next    = bit_cnt;
    done_next   = 1'b0;
    sr_sh_ld_n  = 1'b1;
    sr_clk_inh  = 1'b1;
    tx          = 1'b1;
`ifdef UART_PARITY_EN
    parity_next = parity_bit;
`endif
    case (state)
      IDLE: begin
        baud_next = '0;
        if (accept) begin
          state_next  = START;
          sr_sh_ld_n  = 1'b0;
          sr_clk_inh  = 1'b0;
`ifdef UART_PARITY_EN
          parity_next = (^host.tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        tx = sr_q;
        if (baud_last) begin
          bit_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            // Advance the register to the next data bit; the last bit needs no shift.
            sr_clk_inh = 1'b0;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx = parity_bit;
        if (baud_last) state_next = STOP;
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (baud_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_piso_tx_ctrl.sv
// Self-checking bench for uart_piso_tx_ctrl with a behavioural sn74ls166 model on the register pins.
// Expected line waveforms come from a frame model built from the byte (and UART_PARITY_EN when defined).
module tb_uart_piso_tx_ctrl;

  localparam int CLK_DIV = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam bit ODD   = 1'b0;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       clr_n;
  logic       sr_clr_n, sr_sh_ld_n, sr_clk_inh, sr_ser, sr_q;
  logic [7:0] sr_p;
  logic       tx, busy, tx_done;
  logic [7:0] sr_reg;

  int checks = 0;
  int fails  = 0;

  uart_piso_tx_ctrl_if host ();

`ifdef UART_PARITY_EN
  uart_piso_tx_ctrl #(.CLK_DIV(CLK_DIV), .PARITY_ODD(ODD)) dut (
`else
  uart_piso_tx_ctrl #(.CLK_DIV(CLK_DIV)) dut (
`endif
    .clk        (clk),
    .clr_n      (clr_n),
    .host       (host),
    .sr_clr_n   (sr_clr_n),
    .sr_sh_ld_n (sr_sh_ld_n),
    .sr_clk_inh (sr_clk_inh),
    .sr_ser     (sr_ser),
    .sr_p       (sr_p),
    .sr_q       (sr_q),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 74LS166: async clear, load when SH/LD low, shift toward bit 7 otherwise, inhibited when CLK_INH high.
  always_ff @(posedge clk or negedge sr_clr_n) begin
    if (!sr_clr_n)        sr_reg <= '0;
    else if (!sr_clk_inh) sr_reg <= !sr_sh_ld_n ? sr_p : {sr_reg[6:0], sr_ser};
  end
  assign sr_q = sr_reg[7];

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
    logic [NBITS-1:0] b;
    b[0] = 1'b0;
    for (int j = 0; j < 8; j++) b[1+j] = d[j];
`ifdef UART_PARITY_EN
    b[9] = (^d) ^ ODD;
`endif
    b[NBITS-1] = 1'b1;
    return b;
  endfunction

  // Starts just after a negedge with the controller idle; ends on the negedge of the tx_done cycle.
  task automatic run_frame(input logic [7:0] d, input bit keep_valid, input bit mid_change, input string tag);
    logic [NBITS-1:0] exp_bits;
    logic [7:0]       exp_p;
    int               bit_err [NBITS];
    int               ctrl_err;
    int               shifts;
    exp_bits = frame_bits(d);
    for (int j = 0; j < 8; j++) exp_p[j] = d[7-j];
    host.tx_data  = d;
    host.tx_valid = 1'b1;
    #1;
    checks++; if (host.tx_ready !== 1'b1) begin fails++; $display("[TB] FAIL %s accept_ready: got %b want 1", tag, host.tx_ready); end
    checks++; if (sr_p !== exp_p) begin fails++; $display("[TB] FAIL %s sr_p: got %h want %h", tag, sr_p, exp_p); end
    checks++; if ({sr_sh_ld_n, sr_clk_inh} !== 2'b00) begin fails++; $display("[TB] FAIL %s load_ctrl: got %b want 00", tag, {sr_sh_ld_n, sr_clk_inh}); end
    @(posedge clk);
    ctrl_err = 0;
    shifts   = 0;
    foreach (bit_err[i]) bit_err[i] = 0;
    for (int c = 0; c < NBITS*CLK_DIV; c++) begin
      @(negedge clk);
      if (tx !== exp_bits[c/CLK_DIV]) bit_err[c/CLK_DIV]++;
      if (busy !== 1'b1 || host.tx_ready !== 1'b0 || tx_done !== 1'b0 || sr_sh_ld_n !== 1'b1) ctrl_err++;
      if (sr_clk_inh === 1'b0 && sr_sh_ld_n === 1'b1) shifts++;
      if (c == 0 && !keep_valid) host.tx_valid = 1'b0;
      if (mid_change && c == 2*CLK_DIV*2 + 1) begin
        host.tx_data  = ~d;
        host.tx_valid = 1'b1;
      end
      if (mid_change && c == 2*CLK_DIV*2 + 4) host.tx_valid = 1'b0;
      if (!keep_valid && !mid_change) host.tx_data = 8'($urandom);
    end
    for (int i = 0; i < NBITS; i++) begin
      checks++;
      if (bit_err[i] != 0) begin
        fails++;
        $display("[TB] FAIL %s line_bit%0d: %0d of %0d cycles wrong, want %b", tag, i, bit_err[i], CLK_DIV, exp_bits[i]);
      end
    end
    checks++; if (ctrl_err != 0) begin fails++; $display("[TB] FAIL %s frame_ctrl: %0d bad cycles, want 0", tag, ctrl_err); end
    checks++; if (shifts != 7) begin fails++; $display("[TB] FAIL %s shift_count: got %0d want 7", tag, shifts); end
    @(negedge clk);
    checks++; if (tx_done !== 1'b1) begin fails++; $display("[TB] FAIL %s tx_done: got %b want 1", tag, tx_done); end
    checks++; if (busy !== 1'b0 || host.tx_ready !== 1'b1 || tx !== 1'b1) begin
      fails++; $display("[TB] FAIL %s end_idle: busy=%b ready=%b tx=%b want 0 1 1", tag, busy, host.tx_ready, tx);
    end
  endtask

  task automatic test_reset;
    int err;
    clr_n         = 1'b0;
    host.tx_valid = 1'b0;
    host.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1 || host.tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_outputs: tx=%b ready=%b busy=%b done=%b want 1 1 0 0", tx, host.tx_ready, busy, tx_done);
    end
    checks++; if ({sr_clk_inh, sr_sh_ld_n, sr_ser} !== 3'b111) begin
      fails++; $display("[TB] FAIL reset_sr_ctrl: got %b want 111", {sr_clk_inh, sr_sh_ld_n, sr_ser});
    end
    checks++; if (sr_clr_n !== 1'b0) begin fails++; $display("[TB] FAIL reset_sr_clr: got %b want 0", sr_clr_n); end
    clr_n = 1'b1;
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || host.tx_ready !== 1'b1 || busy !== 1'b0 || sr_clk_inh !== 1'b1 || tx_done !== 1'b0) err++;
    end
    checks++; if (err != 0) begin fails++; $display("[TB] FAIL idle_20: %0d bad cycles, want 0", err); end
    checks++; if (sr_clr_n !== 1'b1) begin fails++; $display("[TB] FAIL release_sr_clr: got %b want 1", sr_clr_n); end
  endtask

  task automatic test_single;
    run_frame(8'h01, 1'b0, 1'b0, "single_01");
  endtask

  task automatic test_back_to_back;
    run_frame(8'hA5, 1'b1, 1'b0, "b2b_A5");
    run_frame(8'h3C, 1'b0, 1'b0, "b2b_3C");
  endtask

  task automatic test_mid_frame;
    int err;
    run_frame(8'h5B, 1'b0, 1'b1, "midchange_5B");
    err = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1 || host.tx_ready !== 1'b1) err++;
    end
    checks++; if (err != 0) begin fails++; $display("[TB] FAIL midchange_no_accept: %0d bad cycles, want 0", err); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int         err;
    d = 8'($urandom);
    host.tx_data  = d;
    host.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host.tx_valid = 1'b0;
    repeat (5*CLK_DIV + 1) @(negedge clk);
    checks++; if (tx !== d[4]) begin fails++; $display("[TB] FAIL abort_pre_bit4: got %b want %b", tx, d[4]); end
    clr_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || sr_clr_n !== 1'b0) begin fails++; $display("[TB] FAIL abort_immediate: tx=%b sr_clr_n=%b want 1 0", tx, sr_clr_n); end
    checks++; if (busy !== 1'b0 || host.tx_ready !== 1'b1 || sr_clk_inh !== 1'b1) begin
      fails++; $display("[TB] FAIL abort_idle: busy=%b ready=%b inh=%b want 0 1 1", busy, host.tx_ready, sr_clk_inh);
    end
    @(negedge clk);
    clr_n = 1'b1;
    err = 0;
    repeat (12*CLK_DIV) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) err++;
    end
    checks++; if (err != 0) begin fails++; $display("[TB] FAIL abort_no_done: %0d bad cycles, want 0", err); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      run_frame(8'($urandom), bit'($urandom_range(0, 1)), 1'b0, $sformatf("random%0d", n));
    end
    host.tx_valid = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  // 0x07 has three ones, so even parity puts a 1 on the line before the stop bit.
  task automatic test_parity;
    run_frame(8'h07, 1'b0, 1'b0, "parity_07");
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_mid_frame;
    test_reset_mid_frame;
    test_random;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
